// File: rtl/switch_allocator_if.sv
// Allocator-side bundle: head-of-buffer request info in, dequeue grants and crossbar control out.
interface switch_allocator_if #(
    parameter int unsigned PORT_NUM  = 5,
    parameter int unsigned PORT_SIZE = 3
);
    logic [PORT_NUM-1:0]                request_i;
    logic [PORT_NUM-1:0][PORT_SIZE-1:0] out_port_i;
    logic [PORT_NUM-1:0]                head_i;
    logic [PORT_NUM-1:0]                tail_i;
    logic [PORT_NUM-1:0]                downstream_ready_i;
    logic [PORT_NUM-1:0]                grant_o;
    logic [PORT_NUM-1:0][PORT_SIZE-1:0] xbar_sel_o;
    logic [PORT_NUM-1:0]                xbar_valid_o;

    modport master (
        output request_i, out_port_i, head_i, tail_i, downstream_ready_i,
        input  grant_o, xbar_sel_o, xbar_valid_o
    );

    modport slave (
        input  request_i, out_port_i, head_i, tail_i, downstream_ready_i,
        output grant_o, xbar_sel_o, xbar_valid_o
    );
endinterface

// File: rtl/switch_allocator.sv
// Per-output round-robin switch allocator with wormhole locking; grants are combinational
// from the current requests and the registered lock/owner/pointer state.
module switch_allocator #(
    parameter int unsigned PORT_NUM  = 5,
    parameter int unsigned PORT_SIZE = 3
) (
    input logic             clk,
    input logic             rst,
    switch_allocator_if.slave bus
);

    logic [PORT_NUM-1:0]                locked_q, locked_d;
    logic [PORT_NUM-1:0][PORT_SIZE-1:0] owner_q, owner_d;
    logic [PORT_NUM-1:0][PORT_SIZE-1:0] rr_ptr_q, rr_ptr_d;

    logic [PORT_NUM-1:0]                grant;
    logic [PORT_NUM-1:0]                valid;
    logic [PORT_NUM-1:0][PORT_SIZE-1:0] sel;

    logic [PORT_SIZE:0]   sum;
    logic [PORT_SIZE-1:0] idx;
    logic [PORT_SIZE-1:0] win;
    logic [PORT_SIZE-1:0] own;
    logic                 found;

    always_comb begin
        grant    = '0;
        valid    = '0;
        sel      = '0;
        locked_d = locked_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        sum      = '0;
        idx      = '0;
        win      = '0;
        own      = '0;
        found    = 1'b0;

        for (int o = 0; o < PORT_NUM; o++) begin
            if (locked_q[o]) begin
                // Mid-packet: only the owning input may use this output, head bit ignored.
                own = owner_q[o];
                if (bus.request_i[own] && (bus.out_port_i[own] == PORT_SIZE'(o)) &&
                    bus.downstream_ready_i[o]) begin
                    grant[own] = 1'b1;
                    valid[o]   = 1'b1;
                    sel[o]     = own;
                    if (bus.tail_i[own]) locked_d[o] = 1'b0;
                end
            end else if (bus.downstream_ready_i[o]) begin
                found = 1'b0;
                win   = '0;
                for (int k = 0; k < PORT_NUM; k++) begin
                    sum = {1'b0, rr_ptr_q[o]} + (PORT_SIZE+1)'(k);
                    if (sum >= (PORT_SIZE+1)'(PORT_NUM)) sum = sum - (PORT_SIZE+1)'(PORT_NUM);
                    idx = sum[PORT_SIZE-1:0];
                    if (!found && bus.request_i[idx] && bus.head_i[idx] &&
                        (bus.out_port_i[idx] == PORT_SIZE'(o))) begin
                        found = 1'b1;
                        win   = idx;
                    end
                end
                if (found) begin
                    grant[win] = 1'b1;
                    valid[o]   = 1'b1;
                    sel[o]     = win;
                    rr_ptr_d[o] = (win == PORT_SIZE'(PORT_NUM - 1)) ? '0 : win + PORT_SIZE'(1);
                    if (!bus.tail_i[win]) begin
                        locked_d[o] = 1'b1;
                        owner_d[o]  = win;
                    end
                end
            end
        end

        if (rst) begin
            grant = '0;
            valid = '0;
            sel   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            locked_q <= '0;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            locked_q <= locked_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign bus.grant_o      = grant;
    assign bus.xbar_valid_o = valid;
    assign bus.xbar_sel_o   = sel;

endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator: reset, single-flit, round-robin, wormhole lock,
// backpressure and reset mid-packet, with hand-computed expectations.
module tb_switch_allocator;

    localparam int unsigned PORT_NUM  = 5;
    localparam int unsigned PORT_SIZE = 3;

    localparam logic [2:0] LOCAL = 3'd0;
    localparam logic [2:0] NORTH = 3'd1;
    localparam logic [2:0] SOUTH = 3'd2;
    localparam logic [2:0] EAST  = 3'd4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    switch_allocator_if #(.PORT_NUM(PORT_NUM), .PORT_SIZE(PORT_SIZE)) bus ();

    switch_allocator #(.PORT_NUM(PORT_NUM), .PORT_SIZE(PORT_SIZE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        bus.request_i          = '0;
        bus.out_port_i         = '0;
        bus.head_i             = '0;
        bus.tail_i             = '0;
        bus.downstream_ready_i = '1;
    endtask

    task automatic set_in(input int i, input logic [2:0] p, input logic h, input logic t);
        bus.request_i[i]  = 1'b1;
        bus.out_port_i[i] = p;
        bus.head_i[i]     = h;
        bus.tail_i[i]     = t;
    endtask

    // Advance past one rising edge; inputs are then driven in the low phase.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_in();
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic [4:0] g, input logic [4:0] v);
        #1;
        chk({tag, ".grant"}, 32'(bus.grant_o), 32'(g));
        chk({tag, ".valid"}, 32'(bus.xbar_valid_o), 32'(v));
    endtask

    logic [4:0] rr_exp [6];

    initial begin
        // 1. reset hold, then release
        clear_in();
        for (int i = 0; i < 5; i++) set_in(i, NORTH, 1'b1, 1'b1);
        chk_out("rst_hold", 5'b00000, 5'b00000);
        chk("rst_hold.sel", 32'(bus.xbar_sel_o), 32'd0);
        tick();
        rst = 1'b0;
        chk_out("rst_release", 5'b00001, 5'b00010);
        chk("rst_release.sel1", 32'(bus.xbar_sel_o[1]), 32'd0);
        tick();

        // 2. single-flit packets keep the output free
        do_reset();
        set_in(3, EAST, 1'b1, 1'b1);
        chk_out("single_w", 5'b01000, 5'b10000);
        chk("single_w.sel4", 32'(bus.xbar_sel_o[4]), 32'd3);
        tick();
        clear_in();
        set_in(0, EAST, 1'b1, 1'b1);
        chk_out("single_l", 5'b00001, 5'b10000);
        chk("single_l.sel4", 32'(bus.xbar_sel_o[4]), 32'd0);
        tick();

        // 3. round-robin among inputs 0,1,2 to NORTH
        do_reset();
        for (int i = 0; i < 3; i++) set_in(i, NORTH, 1'b1, 1'b1);
        rr_exp = '{5'b00001, 5'b00010, 5'b00100, 5'b00001, 5'b00010, 5'b00100};
        for (int c = 0; c < 6; c++) begin
            chk_out($sformatf("rr%0d", c), rr_exp[c], 5'b00010);
            tick();
        end

        // 4. wormhole lock on SOUTH
        do_reset();
        set_in(1, SOUTH, 1'b1, 1'b0);
        set_in(3, SOUTH, 1'b1, 1'b1);
        chk_out("worm_c0", 5'b00010, 5'b00100);
        tick();
        set_in(1, SOUTH, 1'b0, 1'b0);
        chk_out("worm_c1", 5'b00010, 5'b00100);
        tick();
        set_in(1, SOUTH, 1'b0, 1'b1);
        chk_out("worm_c2", 5'b00010, 5'b00100);
        tick();
        bus.request_i[1] = 1'b0;
        chk_out("worm_c3", 5'b01000, 5'b00100);
        chk("worm_c3.sel2", 32'(bus.xbar_sel_o[2]), 32'd3);
        tick();

        // 5. backpressure on a locked LOCAL output
        do_reset();
        set_in(2, LOCAL, 1'b1, 1'b0);
        chk_out("bp_head", 5'b00100, 5'b00001);
        tick();
        set_in(2, LOCAL, 1'b0, 1'b1);
        set_in(4, LOCAL, 1'b1, 1'b1);
        bus.downstream_ready_i[0] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk_out($sformatf("bp_stall%0d", c), 5'b00000, 5'b00000);
            chk($sformatf("bp_stall%0d.sel0", c), 32'(bus.xbar_sel_o[0]), 32'd0);
            tick();
        end
        bus.downstream_ready_i[0] = 1'b1;
        chk_out("bp_resume", 5'b00100, 5'b00001);
        chk("bp_resume.sel0", 32'(bus.xbar_sel_o[0]), 32'd2);
        tick();
        bus.request_i[2] = 1'b0;
        chk_out("bp_next", 5'b10000, 5'b00001);
        tick();

        // 6. reset mid-packet drops the EAST lock
        do_reset();
        set_in(1, EAST, 1'b1, 1'b0);
        chk_out("rmid_head", 5'b00010, 5'b10000);
        tick();
        rst = 1'b1;
        set_in(1, EAST, 1'b0, 1'b0);
        chk_out("rmid_rst", 5'b00000, 5'b00000);
        tick();
        rst = 1'b0;
        clear_in();
        set_in(4, EAST, 1'b1, 1'b1);
        chk_out("rmid_after", 5'b10000, 5'b10000);
        chk("rmid_after.sel4", 32'(bus.xbar_sel_o[4]), 32'd4);
        tick();

        // Protocol corner cases: non-head to a free output, out-of-range port
        clear_in();
        set_in(0, NORTH, 1'b0, 1'b1);
        set_in(1, 3'd5, 1'b1, 1'b1);
        set_in(2, 3'd7, 1'b1, 1'b0);
        chk_out("corner", 5'b00000, 5'b00000);
        tick();
        clear_in();
        set_in(0, NORTH, 1'b1, 1'b1);
        chk_out("corner_after", 5'b00001, 5'b00010);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
